// File: rtl/nios2_computer_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM pipelined slave ports (s1, s2).
// Read latency of 1 or 2 cycles, byte-lane writes, and a global clock enable.
module nios2_computer_onchip_memory_dp #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 14,
    parameter int    DEPTH        = 10240,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "nios2_computer_onchip_memory_dp.hex"
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clken,

    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid
);

    localparam int                BYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    // The power-up image is attached by the device configuration flow, not by this RTL.
    logic unused_init;
    assign unused_init = (INIT_FILE != "");

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Port 0 is s1, port 1 is s2.
    logic [ADDR_WIDTH-1:0] addr      [2];
    logic [BYTES-1:0]      byteen    [2];
    logic [DATA_WIDTH-1:0] wdata     [2];
    logic [DATA_WIDTH-1:0] rdata     [2];
    logic                  rvalid    [2];
    logic                  rd_go     [2];
    logic                  wr_go     [2];
    logic                  in_range  [2];

    assign addr[0]   = s1_address;
    assign addr[1]   = s2_address;
    assign byteen[0] = s1_byteenable;
    assign byteen[1] = s2_byteenable;
    assign wdata[0]  = s1_writedata;
    assign wdata[1]  = s2_writedata;

    // A write wins over a simultaneous read on the same port.
    assign rd_go[0] = clken & s1_chipselect & s1_read & ~s1_write;
    assign rd_go[1] = clken & s2_chipselect & s2_read & ~s2_write;
    assign wr_go[0] = reset_n & clken & s1_chipselect & s1_write;
    assign wr_go[1] = reset_n & clken & s2_chipselect & s2_write;

    assign in_range[0] = ({1'b0, addr[0]} < DEPTH_LIM);
    assign in_range[1] = ({1'b0, addr[1]} < DEPTH_LIM);

    // NOTE: the storage array is deliberately left out of reset so its contents
    // survive reset_n and it can map onto block RAM.
    // NOTE: non-blocking writes here mean a same-cycle read sees the old word.
    // s2 is applied first so s1 overrides it on any lane both ports enable.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (wr_go[p] && in_range[p]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byteen[p][b]) begin
                        mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  v1;
        logic [DATA_WIDTH-1:0] d1;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v1 <= 1'b0;
                d1 <= '0;
            end else if (clken) begin
                v1 <= rd_go[p];
                if (rd_go[p]) begin
                    d1 <= in_range[p] ? mem[addr[p]] : '0;
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;

            // Output register only loads when a word arrives, so readdata
            // holds its last value between bursts.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else if (clken) begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                    end
                end
            end

            assign rdata[p]  = d2;
            assign rvalid[p] = v2;
        end else begin : g_lat1
            assign rdata[p]  = d1;
            assign rvalid[p] = v1;
        end
    end

    assign s1_readdata      = rdata[0];
    assign s1_readdatavalid = rvalid[0];
    assign s2_readdata      = rdata[1];
    assign s2_readdatavalid = rvalid[1];

endmodule

// File: tb/tb_nios2_computer_onchip_memory_dp.sv
// Directed bench: one latency-1 and one latency-2 instance share the same stimulus,
// so both memories hold identical contents throughout.
module tb_nios2_computer_onchip_memory_dp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;

    logic [13:0] s1_address,  s2_address;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic        s1_chipselect, s1_read, s1_write;
    logic        s2_chipselect, s2_read, s2_write;
    logic [31:0] s1_writedata, s2_writedata;

    logic [31:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
    logic        a_s1_readdatavalid, a_s2_readdatavalid;
    logic        b_s1_readdatavalid, b_s2_readdatavalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_computer_onchip_memory_dp #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable),
        .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_readdata(a_s1_readdata),
        .s1_readdatavalid(a_s1_readdatavalid),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable),
        .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_writedata(s2_writedata), .s2_readdata(a_s2_readdata),
        .s2_readdatavalid(a_s2_readdatavalid)
    );

    nios2_computer_onchip_memory_dp #(.READ_LATENCY(2)) dut_l2 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable),
        .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_readdata(b_s1_readdata),
        .s1_readdatavalid(b_s1_readdatavalid),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable),
        .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_writedata(s2_writedata), .s2_readdata(b_s2_readdata),
        .s2_readdatavalid(b_s2_readdatavalid)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic s1_cmd(input logic rd, input logic wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        s1_chipselect = rd | wr;
        s1_read       = rd;
        s1_write      = wr;
        s1_address    = a;
        s1_byteenable = be;
        s1_writedata  = d;
    endtask

    task automatic s2_cmd(input logic rd, input logic wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        s2_chipselect = rd | wr;
        s2_read       = rd;
        s2_write      = wr;
        s2_address    = a;
        s2_byteenable = be;
        s2_writedata  = d;
    endtask

    task automatic idle();
        s1_cmd(1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
        s2_cmd(1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clken   = 1'b1;
        idle();
        #2;
        check("rst_l1_s1_valid", {31'b0, a_s1_readdatavalid}, 32'd0);
        check("rst_l1_s1_data",  a_s1_readdata, 32'h0);
        check("rst_l1_s2_valid", {31'b0, a_s2_readdatavalid}, 32'd0);
        check("rst_l2_s1_data",  b_s1_readdata, 32'h0);
        check("rst_l2_s2_valid", {31'b0, b_s2_readdatavalid}, 32'd0);
        step();
        reset_n = 1'b1;

        // Preload: addr0, addr7, addr1..3.
        s1_cmd(1'b0, 1'b1, 14'd0, 4'hF, 32'h1234_5678);
        s2_cmd(1'b0, 1'b1, 14'd7, 4'hF, 32'h1122_3344);
        step();
        s1_cmd(1'b0, 1'b1, 14'd1, 4'hF, 32'h1111_0001);
        s2_cmd(1'b0, 1'b1, 14'd2, 4'hF, 32'h2222_0002);
        step();
        idle();
        s1_cmd(1'b0, 1'b1, 14'd3, 4'hF, 32'h3333_0003);
        step();

        // Write then read back on the next cycle.
        s1_cmd(1'b0, 1'b1, 14'd5, 4'hF, 32'hDEAD_BEEF);
        step();
        s1_cmd(1'b1, 1'b0, 14'd5, 4'h0, 32'h0);
        step();
        check("l1_rd5_valid", {31'b0, a_s1_readdatavalid}, 32'd1);
        check("l1_rd5_data",  a_s1_readdata, 32'hDEAD_BEEF);
        check("l2_rd5_not_yet", {31'b0, b_s1_readdatavalid}, 32'd0);

        // Partial-lane write on s2.
        idle();
        s2_cmd(1'b0, 1'b1, 14'd7, 4'b0101, 32'hAABB_CCDD);
        step();
        check("l1_rd5_one_pulse", {31'b0, a_s1_readdatavalid}, 32'd0);
        check("l1_rd5_data_hold", a_s1_readdata, 32'hDEAD_BEEF);
        check("l2_rd5_valid", {31'b0, b_s1_readdatavalid}, 32'd1);
        check("l2_rd5_data",  b_s1_readdata, 32'hDEAD_BEEF);
        idle();
        s1_cmd(1'b1, 1'b0, 14'd7, 4'h0, 32'h0);
        step();
        check("l1_byteen_valid", {31'b0, a_s1_readdatavalid}, 32'd1);
        check("l1_byteen_data",  a_s1_readdata, 32'h11BB_33DD);

        // Same-address write collision.
        s1_cmd(1'b0, 1'b1, 14'd9, 4'b0011, 32'hFFFF_FFFF);
        s2_cmd(1'b0, 1'b1, 14'd9, 4'b1111, 32'h0000_0000);
        step();
        idle();
        s2_cmd(1'b1, 1'b0, 14'd9, 4'h0, 32'h0);
        step();
        check("l1_collide_valid", {31'b0, a_s2_readdatavalid}, 32'd1);
        check("l1_collide_data",  a_s2_readdata, 32'h0000_FFFF);

        // Read-during-write across ports returns the old word.
        s1_cmd(1'b0, 1'b1, 14'd5, 4'hF, 32'hCAFE_F00D);
        s2_cmd(1'b1, 1'b0, 14'd5, 4'h0, 32'h0);
        step();
        check("l1_rdw_old", a_s2_readdata, 32'hDEAD_BEEF);
        idle();
        s2_cmd(1'b1, 1'b0, 14'd5, 4'h0, 32'h0);
        step();
        check("l1_rdw_new", a_s2_readdata, 32'hCAFE_F00D);

        // Read and write together on one port act as a write only.
        idle();
        s1_cmd(1'b1, 1'b1, 14'd11, 4'hF, 32'h0BAD_C0DE);
        step();
        check("l1_rdwr_no_valid", {31'b0, a_s1_readdatavalid}, 32'd0);
        idle();
        s1_cmd(1'b1, 1'b0, 14'd11, 4'h0, 32'h0);
        step();
        check("l1_rdwr_written", a_s1_readdata, 32'h0BAD_C0DE);

        // Out-of-range write is dropped; read returns zero but still valid.
        s1_cmd(1'b0, 1'b1, 14'd10240, 4'hF, 32'h5555_5555);
        step();
        s1_cmd(1'b1, 1'b0, 14'd10240, 4'h0, 32'h0);
        step();
        check("l1_oor_valid", {31'b0, a_s1_readdatavalid}, 32'd1);
        check("l1_oor_data",  a_s1_readdata, 32'h0);
        s1_cmd(1'b1, 1'b0, 14'd0, 4'h0, 32'h0);
        step();
        check("l1_addr0_kept", a_s1_readdata, 32'h1234_5678);
        idle();
        step();
        step();

        // Latency-2 burst with a one-cycle clock-enable freeze after the second read.
        s1_cmd(1'b1, 1'b0, 14'd1, 4'h0, 32'h0);
        step();
        s1_cmd(1'b1, 1'b0, 14'd2, 4'h0, 32'h0);
        step();
        check("l2_burst1_valid", {31'b0, b_s1_readdatavalid}, 32'd1);
        check("l2_burst1_data",  b_s1_readdata, 32'h1111_0001);
        clken = 1'b0;
        s1_cmd(1'b1, 1'b0, 14'd3, 4'h0, 32'h0);
        step();
        check("l2_freeze_valid", {31'b0, b_s1_readdatavalid}, 32'd1);
        check("l2_freeze_data",  b_s1_readdata, 32'h1111_0001);
        check("l1_freeze_data",  a_s1_readdata, 32'h2222_0002);
        clken = 1'b1;
        step();
        check("l2_burst2_valid", {31'b0, b_s1_readdatavalid}, 32'd1);
        check("l2_burst2_data",  b_s1_readdata, 32'h2222_0002);
        idle();
        step();
        check("l2_burst3_valid", {31'b0, b_s1_readdatavalid}, 32'd1);
        check("l2_burst3_data",  b_s1_readdata, 32'h3333_0003);
        step();
        check("l2_burst_end",    {31'b0, b_s1_readdatavalid}, 32'd0);
        check("l2_data_hold",    b_s1_readdata, 32'h3333_0003);

        // Reset lands while a latency-2 read is in flight.
        s1_cmd(1'b1, 1'b0, 14'd5, 4'h0, 32'h0);
        step();
        idle();
        reset_n = 1'b0;
        #1;
        check("mid_rst_l2_valid", {31'b0, b_s1_readdatavalid}, 32'd0);
        check("mid_rst_l2_data",  b_s1_readdata, 32'h0);
        check("mid_rst_l1_data",  a_s1_readdata, 32'h0);
        step();
        check("in_rst_l2_valid",  {31'b0, b_s1_readdatavalid}, 32'd0);
        step();
        reset_n = 1'b1;
        s1_cmd(1'b1, 1'b0, 14'd5, 4'h0, 32'h0);
        step();
        check("post_rst_l1_valid", {31'b0, a_s1_readdatavalid}, 32'd1);
        check("post_rst_l1_data",  a_s1_readdata, 32'hCAFE_F00D);
        check("post_rst_l2_stale", {31'b0, b_s1_readdatavalid}, 32'd0);
        idle();
        step();
        check("post_rst_l2_valid", {31'b0, b_s1_readdatavalid}, 32'd1);
        check("post_rst_l2_data",  b_s1_readdata, 32'hCAFE_F00D);
        check("post_rst_l2_s2_zero", b_s2_readdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
